// File: rtl/pre_if_fetch_ctrl_if.sv
// Instruction-bus and IF-handoff signal bundle for the pre-IF fetch sequencer.
// The master modport is the fetch controller; the slave modport is the SRAM bus plus the IF stage.
interface pre_if_fetch_ctrl_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        if_allowin;
  logic        to_valid;
  logic [31:0] to_pc;
  logic [31:0] to_inst;
  logic        to_adef;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    output to_valid, to_pc, to_inst, to_adef,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, if_allowin
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    input  to_valid, to_pc, to_inst, to_adef,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, if_allowin
  );
endinterface

// File: rtl/pre_if_fetch_ctrl.sv
// Fetch sequencer ahead of IF: owns fetch_pc, issues one outstanding SRAM read at a time,
// applies redirects and drops responses belonging to squashed fetches.
//
// state | meaning
// IDLE  | just out of reset, no request yet
// REQ   | request fetch_pc (or present adef when fetch_pc is misaligned)
// WAIT  | request accepted, waiting for data_ok (cancel marks a squashed fetch)
// HOLD  | data returned but IF stalled; word held in inst_buf
module pre_if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ex_WB,
  input  logic [31:0] ex_entry,
  input  logic        flush_WB,
  input  logic [31:0] era,
  pre_if_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] inst_buf;
  logic        cancel;

  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] pc_seq;
  logic        pc_mis;
  logic        wait_hit;

  always_comb begin
    redir = ex_WB | flush_WB | br_taken;
    if (ex_WB)
      redir_pc = ex_entry;
    else if (flush_WB)
      redir_pc = era;
    else
      redir_pc = br_target;
  end

  assign pc_seq   = fetch_pc + 32'd4;
  assign pc_mis   = fetch_pc[1:0] != 2'b00;
  assign wait_hit = (state == WAIT) & bus.inst_sram_data_ok & ~cancel;

  // Delivery is combinational so a word reaches IF in its data_ok cycle.
  assign bus.inst_sram_req  = (state == REQ) & ~pc_mis;
  assign bus.inst_sram_wr   = 1'b0;
  assign bus.inst_sram_size = 2'b10;
  assign bus.inst_sram_addr = fetch_pc;
  assign bus.to_pc          = fetch_pc;
  assign bus.to_adef        = (state == REQ) & pc_mis;
  assign bus.to_valid       = ~redir & (((state == REQ) & pc_mis) | wait_hit | (state == HOLD));
  assign bus.to_inst        = wait_hit ? bus.inst_sram_rdata :
                              (state == HOLD) ? inst_buf : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      cancel   <= 1'b0;
      inst_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (pc_mis) begin
            if (redir)
              fetch_pc <= redir_pc;
            else if (bus.if_allowin)
              fetch_pc <= pc_seq;
          end else if (bus.inst_sram_addr_ok) begin
            state <= WAIT;
            if (redir) begin
              cancel   <= 1'b1;
              fetch_pc <= redir_pc;
            end
          end else if (redir) begin
            fetch_pc <= redir_pc;
          end
        end
        WAIT: begin
          if (bus.inst_sram_data_ok) begin
            cancel <= 1'b0;
            if (redir) begin
              fetch_pc <= redir_pc;
              state    <= REQ;
            end else if (cancel) begin
              state <= REQ;
            end else if (bus.if_allowin) begin
              fetch_pc <= pc_seq;
              state    <= REQ;
            end else begin
              inst_buf <= bus.inst_sram_rdata;
              state    <= HOLD;
            end
          end else if (redir) begin
            // The outstanding response now belongs to a squashed fetch.
            cancel   <= 1'b1;
            fetch_pc <= redir_pc;
          end
        end
        HOLD: begin
          if (redir) begin
            fetch_pc <= redir_pc;
            state    <= REQ;
          end else if (bus.if_allowin) begin
            fetch_pc <= pc_seq;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
